// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, iterative shifts and shift-add multiply,
// registered result and condition flags with a busy/done handshake toward the controller.
module alu_mc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_ena,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] accum,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             v_flag,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned CW  = SW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    // Opcodes not listed here (HLT, SKZ, STO, JMP, 1101-1111) pass A through.
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0011;
    localparam logic [3:0] OpXor = 4'b0100;
    localparam logic [3:0] OpLda = 4'b0101;
    localparam logic [3:0] OpSub = 4'b1000;
    localparam logic [3:0] OpOr  = 4'b1001;
    localparam logic [3:0] OpShl = 4'b1010;
    localparam logic [3:0] OpShr = 4'b1011;
    localparam logic [3:0] OpMul = 4'b1100;

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {KindShl, KindShr, KindMul} kind_e;

    state_e             state_q;
    kind_e              kind_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   alu_out_q;
    logic               z_q, n_q, c_q, v_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   sh_q;
    logic               sout_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c, sc_v;
    logic [WIDTH-1:0]   mc_res;
    logic               mc_c;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v;
    logic [WIDTH-1:0]   sh_step;
    logic               sout_step;
    logic [2*WIDTH-1:0] prod_step;
    logic               start_mul, start_multi;

    assign start_mul   = (opcode == OpMul);
    assign start_multi = (opcode == OpShl) || (opcode == OpShr) || start_mul;

    // Single-cycle datapath, evaluated on the live operands at the accepting edge.
    always_comb begin
        sum_w  = {1'b0, accum} + {1'b0, data};
        diff_w = {1'b0, accum} - {1'b0, data};
        sc_res = accum;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (opcode)
            OpAdd: begin
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (accum[MSB] == data[MSB]) && (sum_w[MSB] != accum[MSB]);
            end
            OpAnd: sc_res = accum & data;
            OpXor: sc_res = accum ^ data;
            OpLda: sc_res = data;
            OpSub: begin
                sc_res = diff_w[WIDTH-1:0];
                sc_c   = diff_w[WIDTH];
                sc_v   = (accum[MSB] != data[MSB]) && (diff_w[MSB] != accum[MSB]);
            end
            OpOr:  sc_res = accum | data;
            default: ;
        endcase
    end

    // One iteration of the multi-cycle datapath.
    always_comb begin
        sh_step   = sh_q;
        sout_step = sout_q;
        if (kind_q == KindShl) begin
            sh_step   = {sh_q[WIDTH-2:0], 1'b0};
            sout_step = sh_q[WIDTH-1];
        end else if (kind_q == KindShr) begin
            sh_step   = {1'b0, sh_q[WIDTH-1:1]};
            sout_step = sh_q[0];
        end
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    end

    always_comb begin
        if (kind_q == KindMul) begin
            mc_res = prod_q[WIDTH-1:0];
            mc_c   = |prod_q[2*WIDTH-1:WIDTH];
        end else begin
            mc_res = sh_q;
            mc_c   = sout_q;
        end
    end

    always_comb begin
        if (state_q == StRun) begin
            fin_res = mc_res;
            fin_c   = mc_c;
            fin_v   = 1'b0;
        end else begin
            fin_res = sc_res;
            fin_c   = sc_c;
            fin_v   = sc_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            kind_q    <= KindShl;
            cnt_q     <= '0;
            alu_out_q <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sh_q      <= '0;
            sout_q    <= 1'b0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (alu_ena) begin
                        if (start_multi) begin
                            state_q  <= StRun;
                            busy_q   <= 1'b1;
                            kind_q   <= start_mul ? KindMul
                                      : ((opcode == OpShl) ? KindShl : KindShr);
                            cnt_q    <= start_mul ? CW'(WIDTH) : {1'b0, data[SW-1:0]};
                            sh_q     <= accum;
                            sout_q   <= 1'b0;
                            prod_q   <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, accum};
                            mplier_q <= data;
                        end else begin
                            alu_out_q <= fin_res;
                            z_q       <= (fin_res == '0);
                            n_q       <= fin_res[MSB];
                            c_q       <= fin_c;
                            v_q       <= fin_v;
                            done_q    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (cnt_q != '0) begin
                        sh_q     <= sh_step;
                        sout_q   <= sout_step;
                        prod_q   <= prod_step;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CW'(1);
                    end else begin
                        alu_out_q <= fin_res;
                        z_q       <= (fin_res == '0);
                        n_q       <= fin_res[MSB];
                        c_q       <= fin_c;
                        v_q       <= fin_v;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_out = alu_out_q;
    assign z_flag  = z_q;
    assign n_flag  = n_q;
    assign c_flag  = c_q;
    assign v_flag  = v_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign zero    = (accum == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): expected results are queued at issue time and
// popped when done is observed.
module tb_alu_mc;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_ena;
    logic [3:0]   opcode;
    logic [W-1:0] data, accum, alu_out;
    logic         zero, z_flag, n_flag, c_flag, v_flag, busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } obs_t;

    obs_t exp_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .alu_ena(alu_ena), .opcode(opcode), .data(data),
        .accum(accum), .alu_out(alu_out), .zero(zero), .z_flag(z_flag),
        .n_flag(n_flag), .c_flag(c_flag), .v_flag(v_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return {alu_out, z_flag, n_flag, c_flag, v_flag};
    endfunction

    function automatic obs_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic obs_t model(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b);
        int unsigned ua, ub, r, s;
        int          sa, sb, sr;
        logic        c, v;
        obs_t        o;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); s = ub % 8;
        c = 1'b0; v = 1'b0; r = ua;
        case (op)
            4'h2: begin r = ua + ub; c = r > 255; sr = sa + sb; v = sr > 127 || sr < -128; end
            4'h3: r = ua & ub;
            4'h4: r = ua ^ ub;
            4'h5: r = ub;
            4'h8: begin r = ua - ub; c = ua < ub; sr = sa - sb; v = sr > 127 || sr < -128; end
            4'h9: r = ua | ub;
            4'hA: begin r = ua << s; c = (s != 0) && (((ua >> (8 - s)) & 1) == 1); end
            4'hB: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            4'hC: begin r = ua * ub; c = r > 255; end
            default: ;
        endcase
        o.res = r[7:0];
        o.z   = (o.res == 8'h00);
        o.n   = o.res[7];
        o.c   = c;
        o.v   = v;
        return o;
    endfunction

    // Issues one op; lat counts edges after acceptance until done is seen (capped).
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output obs_t got, output int lat, output logic busy_seen);
        alu_ena = 1'b1; opcode = op; accum = a; data = b;
        @(posedge clk); #1;
        alu_ena   = 1'b0;
        busy_seen = busy;
        lat       = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        got = cur();
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_ena = 1'b0; opcode = 4'h0; data = 8'h00; accum = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cur() !== obs_t'(12'h000)) begin
            bad++; $display("FAIL reset_state got=%h exp=000", cur());
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            bad++; $display("FAIL reset_ctrl busy=%b done=%b zero=%b exp 0 0 1", busy, done, zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]  ops [4] = '{4'h2, 4'h8, 4'h2, 4'h5};
        logic [7:0]  as  [4] = '{8'hF0, 8'h10, 8'h7F, 8'h33};
        logic [7:0]  bs  [4] = '{8'h20, 8'h20, 8'h01, 8'h00};
        logic [11:0] ex  [4] = '{12'h102, 12'hF06, 12'h805, 12'h008};
        obs_t got, exp;
        int   lat;
        logic bsy;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(obs_t'(ex[i]));
            run_op(ops[i], as[i], bs[i], got, lat, bsy);
            exp = pop_exp();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL single_%0d got=%h exp=%h", i, got, exp);
            end
            total++;
            if (lat !== 0 || bsy !== 1'b0) begin
                bad++; $display("FAIL single_timing_%0d lat=%0d busy=%b exp 0 0", i, lat, bsy);
            end
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) begin
                bad++; $display("FAIL single_done_width_%0d done=%b exp 0", i, done);
            end
        end
        for (int i = 0; i < 6; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = (i % 3 == 0) ? 4'h2 : ((i % 3 == 1) ? 4'h8 : 4'h9);
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            exp_q.push_back(model(op, a, b));
            run_op(op, a, b, got, lat, bsy);
            exp = pop_exp();
            total++;
            if (got !== exp || lat !== 0) begin
                bad++; $display("FAIL single_rand op=%h a=%h b=%h got=%h lat=%0d exp=%h lat=0",
                                op, a, b, got, lat, exp);
            end
        end
    endtask

    task automatic test_legacy();
        logic [7:0] ex [8] = '{8'h3C, 8'h3C, 8'h4B, 8'h0C, 8'h33, 8'h0F, 8'h3C, 8'h3C};
        obs_t got, exp;
        int   lat;
        logic bsy;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(obs_t'({ex[i], 4'b0000}));
            run_op(4'(i), 8'h3C, 8'h0F, got, lat, bsy);
            exp = pop_exp();
            total++;
            if (got !== exp || lat !== 0) begin
                bad++; $display("FAIL legacy_op%0d got=%h lat=%0d exp=%h lat=0", i, got, lat, exp);
            end
        end
    endtask

    task automatic test_shift();
        obs_t got, exp;
        int   lat;
        logic bsy;
        exp_q.push_back(obs_t'(12'h080));
        run_op(4'hA, 8'h81, 8'h03, got, lat, bsy);
        exp = pop_exp();
        total++;
        if (got !== exp || lat !== 4 || bsy !== 1'b1) begin
            bad++; $display("FAIL shl_81_3 got=%h lat=%0d busy=%b exp=%h lat=4 busy=1",
                            got, lat, bsy, exp);
        end
        exp_q.push_back(obs_t'(12'h814));
        run_op(4'hB, 8'h81, 8'h00, got, lat, bsy);
        exp = pop_exp();
        total++;
        if (got !== exp || lat !== 1) begin
            bad++; $display("FAIL shr_81_0 got=%h lat=%0d exp=%h lat=1", got, lat, exp);
        end
        for (int i = 0; i < 8; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = (i % 2 == 0) ? 4'hA : 4'hB;
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            exp_q.push_back(model(op, a, b));
            run_op(op, a, b, got, lat, bsy);
            exp = pop_exp();
            total++;
            if (got !== exp || lat !== 1 + int'(b[2:0])) begin
                bad++; $display("FAIL shift_rand op=%h a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                                op, a, b, got, lat, exp, 1 + int'(b[2:0]));
            end
        end
    endtask

    task automatic test_mul();
        obs_t got, exp;
        int   lat;
        logic bsy;
        exp_q.push_back(obs_t'(12'hFC4));
        run_op(4'hC, 8'h12, 8'h0E, got, lat, bsy);
        exp = pop_exp();
        total++;
        if (got !== exp || lat !== 9 || bsy !== 1'b1) begin
            bad++; $display("FAIL mul_12_0e got=%h lat=%0d busy=%b exp=%h lat=9 busy=1",
                            got, lat, bsy, exp);
        end
        exp_q.push_back(obs_t'(12'h00A));
        run_op(4'hC, 8'h20, 8'h10, got, lat, bsy);
        exp = pop_exp();
        total++;
        if (got !== exp || lat !== 9) begin
            bad++; $display("FAIL mul_20_10 got=%h lat=%0d exp=%h lat=9", got, lat, exp);
        end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(model(4'hC, a, b));
            run_op(4'hC, a, b, got, lat, bsy);
            exp = pop_exp();
            total++;
            if (got !== exp || lat !== 9) begin
                bad++; $display("FAIL mul_rand a=%h b=%h got=%h lat=%0d exp=%h lat=9",
                                a, b, got, lat, exp);
            end
        end
    endtask

    // Requests during RUN, including the completing edge, must be dropped.
    task automatic test_busy_ignore();
        obs_t got, exp;
        int   ndone, lat;
        exp_q.push_back(model(4'hC, 8'h0B, 8'h0D));
        alu_ena = 1'b1; opcode = 4'hC; accum = 8'h0B; data = 8'h0D;
        @(posedge clk); #1;
        alu_ena = 1'b0;
        ndone = 0; lat = -1; got = 'x;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3 || i == 9) begin
                alu_ena = 1'b1; opcode = 4'h2; accum = 8'h01; data = 8'h01;
            end
            if (i == 4 || i == 10) alu_ena = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++; lat = i; got = cur();
            end
        end
        exp = pop_exp();
        total++;
        if (ndone !== 1 || lat !== 9) begin
            bad++; $display("FAIL busy_ignore_done count=%0d lat=%0d exp 1 9", ndone, lat);
        end
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL busy_ignore_result got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_mid_reset();
        obs_t got, exp;
        int   lat, ndone;
        logic bsy;
        exp_q.push_back(obs_t'(12'h030));
        run_op(4'h2, 8'h01, 8'h02, got, lat, bsy);
        exp = pop_exp();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL pre_reset_add got=%h exp=%h", got, exp);
        end
        alu_ena = 1'b1; opcode = 4'hC; accum = 8'hFF; data = 8'hFF;
        @(posedge clk); #1;
        alu_ena = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || cur() !== obs_t'(12'h000)) begin
            bad++; $display("FAIL mid_reset_state busy=%b done=%b out=%h exp 0 0 000",
                            busy, done, cur());
        end
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++; $display("FAIL mid_reset_no_done count=%0d exp 0", ndone);
        end
        exp_q.push_back(obs_t'(12'h805));
        run_op(4'h2, 8'h7F, 8'h01, got, lat, bsy);
        exp = pop_exp();
        total++;
        if (got !== exp || lat !== 0) begin
            bad++; $display("FAIL post_reset_add got=%h lat=%0d exp=%h lat=0", got, lat, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp;
        exp_q.push_back(obs_t'(12'h300));
        exp_q.push_back(obs_t'(12'hAA4));
        alu_ena = 1'b1; opcode = 4'h2; accum = 8'h10; data = 8'h20;
        @(posedge clk); #1;
        exp = pop_exp();
        total++;
        if (done !== 1'b1 || cur() !== exp) begin
            bad++; $display("FAIL b2b_first done=%b got=%h exp 1 %h", done, cur(), exp);
        end
        opcode = 4'h4; accum = 8'h55; data = 8'hFF;
        @(posedge clk); #1;
        alu_ena = 1'b0;
        exp = pop_exp();
        total++;
        if (done !== 1'b1 || cur() !== exp) begin
            bad++; $display("FAIL b2b_second done=%b got=%h exp 1 %h", done, cur(), exp);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || cur() !== exp) begin
            bad++; $display("FAIL b2b_hold done=%b got=%h exp 0 %h", done, cur(), exp);
        end
    endtask

    task automatic test_zero();
        obs_t got, exp;
        int   lat;
        alu_ena = 1'b0; accum = 8'h00;
        #1;
        total++;
        if (zero !== 1'b1) begin bad++; $display("FAIL zero_idle got=%b exp 1", zero); end
        accum = 8'h40;
        #1;
        total++;
        if (zero !== 1'b0) begin bad++; $display("FAIL zero_nonzero got=%b exp 0", zero); end
        exp_q.push_back(model(4'hC, 8'h05, 8'h07));
        alu_ena = 1'b1; opcode = 4'hC; accum = 8'h05; data = 8'h07;
        @(posedge clk); #1;
        alu_ena = 1'b0; accum = 8'h00;
        #1;
        total++;
        if (zero !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL zero_in_run zero=%b busy=%b exp 1 1", zero, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        got = cur();
        exp = pop_exp();
        total++;
        if (got !== exp || lat !== 9) begin
            bad++; $display("FAIL zero_run_mul got=%h lat=%0d exp=%h lat=9", got, lat, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_legacy();
        test_shift();
        test_mul();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        test_zero();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_left entries=%0d exp 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
